instr_rom_fetch: RTL and testbench

Parametrised synchronous instruction ROM with an integrated fetch sequencer for the ARM-64 core front end. It holds a program counter, reads one instruction word per accepted fetch, and presents it to decode over a valid/ready handshake. It supports branch redirect, fetch gating, and an out-of-range fault that halts fetch until the next redirect.

---
 rtl/instr_rom_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_rom_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_rom_fetch.sv
// Instruction ROM with an integrated fetch sequencer.
// Holds the program counter, reads one word per accepted fetch and presents
// it over a valid/ready handshake. Supports branch redirect, fetch gating and
// an out-of-range fault that parks the sequencer in HALT until a redirect.
module instr_rom_fetch #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 64,
    parameter int                 DEPTH     = 16,
    parameter logic [DATA_W-1:0]  FILL_WORD = DATA_W'(32'hD503201F),
    parameter logic [DATA_W-1:0]  OOR_WORD  = '0,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_fault,
    output logic              halted
);

    localparam int                BYTES      = DATA_W / 8;
    localparam int                ALIGN      = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    // ROM contents are an arithmetic fill: entry i = FILL_WORD + i (mod 2^DATA_W).
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] idx);
        return FILL_WORD + DATA_W'(idx);
    endfunction

    // A word index at or beyond DEPTH has no backing storage.
    function automatic logic idx_oor(input logic [ADDR_W-1:0] idx);
        return (idx >= DEPTH_A);
    endfunction

    state_t              state_r, state_n;
    logic [ADDR_W-1:0]   pc_r, pc_n;
    logic                valid_r, valid_n;
    logic [DATA_W-1:0]   instr_r, instr_n;
    logic [ADDR_W-1:0]   instr_pc_r, instr_pc_n;
    logic                fault_r, fault_n;
    logic                halted_r, halted_n;
    logic [ADDR_W-1:0]   idx_s;
    logic                oor_s;
    logic                slot_free_s;

    assign idx_s       = pc_r >> ALIGN;
    assign oor_s       = idx_oor(idx_s);
    assign slot_free_s = ~valid_r | instr_ready;

    // Next-state and next-output decode; redirect overrides everything.
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        valid_n    = valid_r;
        instr_n    = instr_r;
        instr_pc_n = instr_pc_r;
        fault_n    = fault_r;
        if (redirect_valid) begin
            // Flush any pending word and restart from the aligned target.
            valid_n = 1'b0;
            pc_n    = redirect_pc & ALIGN_MASK;
            state_n = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (slot_free_s) begin
                        if (fetch_en) begin
                            instr_n    = oor_s ? OOR_WORD : rom_word(idx_s);
                            instr_pc_n = pc_r;
                            fault_n    = oor_s;
                            valid_n    = 1'b1;
                            pc_n       = pc_r + PC_STEP;
                            if (oor_s) begin
                                state_n = ST_HALT;
                            end else begin
                                state_n = ST_FETCH;
                            end
                        end else begin
                            // Gated: retire a consumed word, never drop an unconsumed one.
                            valid_n = 1'b0;
                        end
                    end else begin
                        // Back-pressured: everything holds so the word stays stable.
                        valid_n = valid_r;
                    end
                end
                ST_HALT: begin
                    if (slot_free_s) begin
                        valid_n = 1'b0;
                    end else begin
                        valid_n = valid_r;
                    end
                end
                default: begin
                    state_n = ST_FETCH;
                    valid_n = 1'b0;
                end
            endcase
        end
        halted_n = (state_n == ST_HALT);
    end

    // State, program counter and registered output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC_A;
            valid_r    <= 1'b0;
            instr_r    <= '0;
            instr_pc_r <= '0;
            fault_r    <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_n;
            pc_r       <= pc_n;
            valid_r    <= valid_n;
            instr_r    <= instr_n;
            instr_pc_r <= instr_pc_n;
            fault_r    <= fault_n;
            halted_r   <= halted_n;
        end
    end

    assign instr_valid = valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_fault = fault_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_instr_rom_fetch.sv
// Directed testbench for instr_rom_fetch. A second instance with a
// top-of-address-space reset PC covers the wrap/out-of-range-at-reset case.
module tb_instr_rom_fetch;

    logic         clk;
    logic         rst_n;
    logic         rst_w_n;
    logic         fetch_en;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         instr_ready;

    logic         instr_valid, instr_fault, halted;
    logic [31:0]  instr;
    logic [63:0]  instr_pc;
    logic         w_valid, w_fault, w_halted;
    logic [31:0]  w_instr;
    logic [63:0]  w_pc;

    // {valid, instr, instr_pc, fault, halted}
    logic [98:0]  obs, obs_w, exp;
    int           errors = 0;
    int           checks = 0;

    assign obs   = {instr_valid, instr, instr_pc, instr_fault, halted};
    assign obs_w = {w_valid, w_instr, w_pc, w_fault, w_halted};

    instr_rom_fetch dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_fault(instr_fault), .halted(halted)
    );

    instr_rom_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_w_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(w_valid), .instr(w_instr),
        .instr_pc(w_pc), .instr_fault(w_fault), .halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_w_n = 1'b0;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; instr_ready = 1'b0;
        tick(); tick();
        exp = {1'b0, 32'h0, 64'h0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset: got %h want %h", obs, exp); end
        checks++;
        if (obs_w !== exp) begin errors++; $display("FAIL reset_w: got %h want %h", obs_w, exp); end
    endtask

    task automatic test_stream();
        fetch_en = 1'b1; instr_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        exp = {1'b1, 32'hD503201F, 64'h0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stream0: got %h want %h", obs, exp); end
        tick();
        exp = {1'b1, 32'hD5032020, 64'h4, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stream1: got %h want %h", obs, exp); end
        tick();
        exp = {1'b1, 32'hD5032021, 64'h8, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stream2: got %h want %h", obs, exp); end
    endtask

    task automatic test_backpressure();
        redirect_valid = 1'b1; redirect_pc = 64'h4;
        tick();
        exp = {1'b0, 32'hD5032021, 64'h8, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bp_redirect: got %h want %h", obs, exp); end
        redirect_valid = 1'b0;
        tick();
        exp = {1'b1, 32'hD5032020, 64'h4, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bp_first: got %h want %h", obs, exp); end
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL bp_hold%0d: got %h want %h", i, obs, exp); end
        end
        instr_ready = 1'b1;
        tick();
        exp = {1'b1, 32'hD5032021, 64'h8, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bp_resume: got %h want %h", obs, exp); end
        tick();
        exp = {1'b1, 32'hD5032022, 64'hC, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bp_next: got %h want %h", obs, exp); end
    endtask

    task automatic test_oor();
        redirect_valid = 1'b1; redirect_pc = 64'h3C;
        tick();
        redirect_valid = 1'b0;
        tick();
        exp = {1'b1, 32'hD503202E, 64'h3C, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL oor_last: got %h want %h", obs, exp); end
        tick();
        exp = {1'b1, 32'h0, 64'h40, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL oor_fault: got %h want %h", obs, exp); end
        instr_ready = 1'b0;
        tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL oor_hold: got %h want %h", obs, exp); end
        instr_ready = 1'b1;
        tick();
        exp = {1'b0, 32'h0, 64'h40, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL oor_consumed: got %h want %h", obs, exp); end
        tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL oor_nofetch: got %h want %h", obs, exp); end
    endtask

    task automatic test_halt_redirect();
        redirect_valid = 1'b1; redirect_pc = 64'h0B;
        tick();
        exp = {1'b0, 32'h0, 64'h40, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL halt_redir: got %h want %h", obs, exp); end
        redirect_valid = 1'b0;
        tick();
        exp = {1'b1, 32'hD5032021, 64'h8, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL halt_align: got %h want %h", obs, exp); end
    endtask

    task automatic test_redirect_flush();
        instr_ready = 1'b0;
        tick();
        exp = {1'b1, 32'hD5032021, 64'h8, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL flush_pending: got %h want %h", obs, exp); end
        redirect_valid = 1'b1; redirect_pc = 64'h20;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", instr_valid); end
        redirect_valid = 1'b0;
        tick();
        exp = {1'b1, 32'hD5032027, 64'h20, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL flush_new: got %h want %h", obs, exp); end
    endtask

    task automatic test_fetch_gate();
        fetch_en = 1'b0;
        tick();
        exp = {1'b1, 32'hD5032027, 64'h20, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL gate_keep: got %h want %h", obs, exp); end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL gate_retire: got %b want 0", instr_valid); end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL gate_idle: got %b want 0", instr_valid); end
        fetch_en = 1'b1;
        tick();
        exp = {1'b1, 32'hD5032028, 64'h24, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL gate_resume: got %h want %h", obs, exp); end
    endtask

    task automatic test_async_reset();
        tick();
        rst_n = 1'b0;
        #1;
        exp = {1'b0, 32'h0, 64'h0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL areset_now: got %h want %h", obs, exp); end
        #2;
        rst_n = 1'b1;
        tick();
        exp = {1'b1, 32'hD503201F, 64'h0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL areset_restart: got %h want %h", obs, exp); end
    endtask

    task automatic test_wrap();
        rst_w_n = 1'b1;
        tick();
        exp = {1'b1, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1};
        checks++;
        if (obs_w !== exp) begin errors++; $display("FAIL wrap_fault: got %h want %h", obs_w, exp); end
        tick();
        exp = {1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1};
        checks++;
        if (obs_w !== exp) begin errors++; $display("FAIL wrap_halt: got %h want %h", obs_w, exp); end
        redirect_valid = 1'b1; redirect_pc = 64'h10;
        tick();
        checks++;
        if (w_halted !== 1'b0) begin errors++; $display("FAIL wrap_unhalt: got %b want 0", w_halted); end
        redirect_valid = 1'b0;
        tick();
        exp = {1'b1, 32'hD5032023, 64'h10, 1'b0, 1'b0};
        checks++;
        if (obs_w !== exp) begin errors++; $display("FAIL wrap_redirect: got %h want %h", obs_w, exp); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_oor();
        test_halt_redirect();
        test_redirect_flush();
        test_fetch_gate();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
